loctag_det_seq: RTL and testbench

- Sequencer for the LocTag detector front end: LT5534 power detector enable plus serial ADC (CS/SCLK/SDO, 16-clock frame, 4 leading zeros, 12 data bits MSB first).
- On a trigger or forced free-run, powers the detector and waits for warm-up. Then runs a burst of NSAMP conversions and streams each sample out.
- Counts samples at or above a threshold and flags a detection at burst end.
- Sits between the pin-level detector interface and the tag's decision/reflector logic, inside the loctag core.

---
 rtl/loctag_det_seq.sv | 208 ++++++++++++++++++++
 tb/tb_loctag_det_seq.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/loctag_det_seq.sv
// LocTag detector front-end sequencer: powers the LT5534, runs a burst of serial
// ADC conversions, streams each sample and flags a detection from the hit count.
module loctag_det_seq #(
  parameter int CLK_DIV    = 2,
  parameter int WARMUP_CYC = 50,
  parameter int NSAMP      = 4,
  parameter int GAP_CYC    = 10,
  parameter int HIT_MIN    = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        trig,
  input  logic                        force_fs,
  input  logic [11:0]                 thresh,
  output logic                        lt5534_en,
  output logic                        adc_cs,
  output logic                        adc_clk,
  input  logic                        adc_so,
  output logic                        sample_valid,
  output logic [11:0]                 sample_data,
  output logic                        burst_done,
  output logic [$clog2(NSAMP+1)-1:0]  hit_count,
  output logic                        detect,
  output logic                        busy
);

  localparam int CW   = $clog2(NSAMP + 1);
  localparam int TMAX = (WARMUP_CYC > GAP_CYC) ? WARMUP_CYC : GAP_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int DW   = $clog2(CLK_DIV + 1);

  localparam logic [TW-1:0] WARM_LAST = TW'(WARMUP_CYC - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYC - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] NSAMP_C   = CW'(NSAMP);
  localparam logic [CW-1:0] HIT_MIN_C = CW'(HIT_MIN);

  typedef enum logic [2:0] {
    S_IDLE, S_WARMUP, S_CONV, S_GAP, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [DW-1:0]   div_q, div_d;
  logic [4:0]      half_q, half_d;
  logic [11:0]     shift_q, shift_d;
  logic [CW-1:0]   samp_q, samp_d;
  logic [CW-1:0]   hits_q, hits_d;
  logic            en_q, en_d;
  logic            cs_q, cs_d;
  logic            sclk_q, sclk_d;
  logic            sv_q, sv_d;
  logic [11:0]     sdata_q, sdata_d;
  logic            bd_q, bd_d;
  logic [CW-1:0]   hit_count_q, hit_count_d;
  logic            detect_q, detect_d;
  logic            busy_q, busy_d;
  logic            start_conv;

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    div_d       = div_q;
    half_d      = half_q;
    shift_d     = shift_q;
    samp_d      = samp_q;
    hits_d      = hits_q;
    en_d        = en_q;
    cs_d        = cs_q;
    sclk_d      = sclk_q;
    sv_d        = 1'b0;
    sdata_d     = sdata_q;
    bd_d        = 1'b0;
    hit_count_d = hit_count_q;
    detect_d    = detect_q;
    busy_d      = busy_q;
    start_conv  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (trig || force_fs) begin
          state_d = S_WARMUP;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          tmr_d   = '0;
          hits_d  = '0;
          samp_d  = '0;
        end
      end
      S_WARMUP: begin
        if (tmr_q == WARM_LAST) start_conv = 1'b1;
        else                    tmr_d = tmr_q + 1'b1;
      end
      S_CONV: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (half_q == 5'd31) begin
            // Last high phase done: the 12 data bits sit in the shifter.
            state_d = S_GAP;
            cs_d    = 1'b1;
            sv_d    = 1'b1;
            sdata_d = shift_q;
            samp_d  = samp_q + 1'b1;
            tmr_d   = '0;
            if (shift_q >= thresh) hits_d = hits_q + 1'b1;
          end else begin
            half_d = half_q + 5'd1;
            sclk_d = ~sclk_q;
            if (!sclk_q) shift_d = {shift_q[10:0], adc_so};
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_GAP: begin
        if (tmr_q == GAP_LAST) begin
          if (samp_q == NSAMP_C) begin
            state_d     = S_DONE;
            bd_d        = 1'b1;
            hit_count_d = hits_q;
            detect_d    = (hits_q >= HIT_MIN_C);
          end else begin
            start_conv = 1'b1;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_DONE: begin
        // Free-run keeps the detector warm and chains straight into the next burst.
        if (force_fs) begin
          start_conv = 1'b1;
          hits_d     = '0;
          samp_d     = '0;
        end else begin
          state_d = S_IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        en_d    = 1'b0;
        busy_d  = 1'b0;
        cs_d    = 1'b1;
        sclk_d  = 1'b1;
      end
    endcase

    if (start_conv) begin
      state_d = S_CONV;
      cs_d    = 1'b0;
      sclk_d  = 1'b0;
      div_d   = '0;
      half_d  = '0;
      shift_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      div_q       <= '0;
      half_q      <= '0;
      shift_q     <= '0;
      samp_q      <= '0;
      hits_q      <= '0;
      en_q        <= 1'b0;
      cs_q        <= 1'b1;
      sclk_q      <= 1'b1;
      sv_q        <= 1'b0;
      sdata_q     <= '0;
      bd_q        <= 1'b0;
      hit_count_q <= '0;
      detect_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      div_q       <= div_d;
      half_q      <= half_d;
      shift_q     <= shift_d;
      samp_q      <= samp_d;
      hits_q      <= hits_d;
      en_q        <= en_d;
      cs_q        <= cs_d;
      sclk_q      <= sclk_d;
      sv_q        <= sv_d;
      sdata_q     <= sdata_d;
      bd_q        <= bd_d;
      hit_count_q <= hit_count_d;
      detect_q    <= detect_d;
      busy_q      <= busy_d;
    end
  end

  assign lt5534_en    = en_q;
  assign adc_cs       = cs_q;
  assign adc_clk      = sclk_q;
  assign sample_valid = sv_q;
  assign sample_data  = sdata_q;
  assign burst_done   = bd_q;
  assign hit_count    = hit_count_q;
  assign detect       = detect_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_loctag_det_seq.sv
// Directed bench for loctag_det_seq: default-parameter instance plus a CLK_DIV=1
// instance for frame timing and bit order, each fed by a serial ADC model.
module tb_loctag_det_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, trig, force_fs, adc_so;
  logic [11:0] thresh;
  logic        lt5534_en, adc_cs, adc_clk, sample_valid, burst_done, detect, busy;
  logic [11:0] sample_data;
  logic [2:0]  hit_count;

  logic        trig1, force1, adc_so1;
  logic [11:0] thresh1;
  logic        en1, cs1, sclk1, sv1, bd1, detect1, busy1;
  logic [11:0] sdata1;
  logic        hit1;

  loctag_det_seq #(.CLK_DIV(2), .WARMUP_CYC(50), .NSAMP(4), .GAP_CYC(10), .HIT_MIN(2)) dut (
    .clk(clk), .reset(reset), .trig(trig), .force_fs(force_fs), .thresh(thresh),
    .lt5534_en(lt5534_en), .adc_cs(adc_cs), .adc_clk(adc_clk), .adc_so(adc_so),
    .sample_valid(sample_valid), .sample_data(sample_data), .burst_done(burst_done),
    .hit_count(hit_count), .detect(detect), .busy(busy)
  );

  loctag_det_seq #(.CLK_DIV(1), .WARMUP_CYC(3), .NSAMP(1), .GAP_CYC(2), .HIT_MIN(1)) dut1 (
    .clk(clk), .reset(reset), .trig(trig1), .force_fs(force1), .thresh(thresh1),
    .lt5534_en(en1), .adc_cs(cs1), .adc_clk(sclk1), .adc_so(adc_so1),
    .sample_valid(sv1), .sample_data(sdata1), .burst_done(bd1),
    .hit_count(hit1), .detect(detect1), .busy(busy1)
  );

  // ADC models: frame loaded on CS fall, bit (15 - rises seen) presented on SDO.
  logic [15:0] frames [4];
  int          fidx = 0;
  logic [15:0] cur_frame = 16'h0;
  int          nrise = 16;
  always @(negedge adc_cs) begin
    cur_frame = frames[fidx % 4];
    fidx++;
    nrise = 0;
  end
  always @(posedge adc_clk) if (adc_cs === 1'b0) nrise++;
  assign adc_so = (nrise < 16) ? cur_frame[15 - nrise] : 1'b0;

  logic [15:0] frame1 = 16'h0ABC;
  int          nrise1 = 16;
  always @(negedge cs1) nrise1 = 0;
  always @(posedge sclk1) if (cs1 === 1'b0) nrise1++;
  assign adc_so1 = (nrise1 < 16) ? frame1[15 - nrise1] : 1'b0;

  // Event monitors, sampled 1 time unit after each rising edge.
  int         cyc = 0;
  int         sv_cnt = 0, bd_cnt = 0, en_rise_cnt = 0, en_fall_cnt = 0, cs_fall_cnt = 0;
  int         en_rise_cyc = 0, warm_meas = -1, bd_cyc_last = 0, bd_gap = -1;
  bit         await_fall = 1'b0;
  logic       prev_en = 1'b0, prev_cs = 1'b1;
  int         sv_cyc_q[$];
  logic [11:0] sv_dat_q[$];

  int         sv1_cnt = 0, bd1_cnt = 0, cs1_run = 0, cs1_len = -1, cs1_fall_cyc = 0;
  int         conv_len1 = -1, nrise1_end = -1;
  logic       prev_cs1 = 1'b1;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (prev_en === 1'b0 && lt5534_en === 1'b1) begin
      en_rise_cnt++;
      en_rise_cyc = cyc;
      await_fall = 1'b1;
    end
    if (prev_en === 1'b1 && lt5534_en === 1'b0) en_fall_cnt++;
    if (prev_cs === 1'b1 && adc_cs === 1'b0) begin
      cs_fall_cnt++;
      if (await_fall) begin
        warm_meas = cyc - en_rise_cyc;
        await_fall = 1'b0;
      end
    end
    if (sample_valid === 1'b1) begin
      sv_cnt++;
      sv_cyc_q.push_back(cyc);
      sv_dat_q.push_back(sample_data);
    end
    if (burst_done === 1'b1) begin
      bd_cnt++;
      bd_gap = cyc - bd_cyc_last;
      bd_cyc_last = cyc;
    end
    prev_en = lt5534_en;
    prev_cs = adc_cs;

    if (prev_cs1 === 1'b1 && cs1 === 1'b0) cs1_fall_cyc = cyc;
    if (cs1 === 1'b0) cs1_run++;
    else if (prev_cs1 === 1'b0) begin
      cs1_len = cs1_run;
      cs1_run = 0;
      nrise1_end = nrise1;
    end
    if (sv1 === 1'b1) begin
      sv1_cnt++;
      conv_len1 = cyc - cs1_fall_cyc;
    end
    if (bd1 === 1'b1) bd1_cnt++;
    prev_cs1 = cs1;
  end

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_bd(input int target, input int budget);
    int n = 0;
    while (bd_cnt < target && n < budget) begin
      tick(1);
      n++;
    end
    check("burst_done_reached", 32'(bd_cnt >= target), 32'd1);
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    tick(1);
    trig = 1'b0;
  endtask

  task automatic set_frames(input logic [15:0] f0, input logic [15:0] f1,
                            input logic [15:0] f2, input logic [15:0] f3);
    frames[0] = f0; frames[1] = f1; frames[2] = f2; frames[3] = f3;
    fidx = 0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_en"},     32'(lt5534_en),    32'd0);
    check({pfx, "_cs"},     32'(adc_cs),       32'd1);
    check({pfx, "_sclk"},   32'(adc_clk),      32'd1);
    check({pfx, "_sv"},     32'(sample_valid), 32'd0);
    check({pfx, "_sdata"},  32'(sample_data),  32'd0);
    check({pfx, "_bd"},     32'(burst_done),   32'd0);
    check({pfx, "_hits"},   32'(hit_count),    32'd0);
    check({pfx, "_detect"}, 32'(detect),       32'd0);
    check({pfx, "_busy"},   32'(busy),         32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base_sv, base_bd, base_cs, n;
    reset = 1'b1; trig = 1'b0; force_fs = 1'b0; thresh = 12'd0;
    trig1 = 1'b0; force1 = 1'b0; thresh1 = 12'hABC;
    set_frames(16'h0FA0, 16'h0FA0, 16'h0FA0, 16'h0FA0);

    // Reset values, then 100 idle cycles with no activity.
    tick(3);
    check_reset_outputs("rst");
    reset = 1'b0;
    sv_cnt = 0; bd_cnt = 0; en_rise_cnt = 0; cs_fall_cnt = 0;
    tick(100);
    check("idle_sv_cnt", 32'(sv_cnt), 32'd0);
    check("idle_bd_cnt", 32'(bd_cnt), 32'd0);
    check("idle_en_rises", 32'(en_rise_cnt), 32'd0);
    check("idle_cs_falls", 32'(cs_fall_cnt), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_sclk", 32'(adc_clk), 32'd1);

    // Single burst, every frame 4000, thresh 1000.
    thresh = 12'd1000;
    sv_cyc_q.delete(); sv_dat_q.delete();
    pulse_trig();
    check("trig_en", 32'(lt5534_en), 32'd1);
    check("trig_busy", 32'(busy), 32'd1);
    check("trig_cs_high", 32'(adc_cs), 32'd1);
    wait_bd(1, 2000);
    tick(2);
    check("warmup_len", 32'(warm_meas), 32'd50);
    check("b1_sv_count", 32'(sv_cyc_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) check("b1_sample_data", 32'(sv_dat_q[i]), 32'd4000);
    for (int i = 1; i < 4; i++) check("b1_sv_spacing", 32'(sv_cyc_q[i] - sv_cyc_q[i-1]), 32'd74);
    check("b1_bd_count", 32'(bd_cnt), 32'd1);
    check("b1_hits", 32'(hit_count), 32'd4);
    check("b1_detect", 32'(detect), 32'd1);
    check("b1_en_off", 32'(lt5534_en), 32'd0);
    check("b1_idle", 32'(busy), 32'd0);

    // Threshold boundary: equality counts as a hit.
    set_frames(16'd500, 16'd1000, 16'd999, 16'd1001);
    pulse_trig();
    wait_bd(2, 2000);
    check("b2_hits", 32'(hit_count), 32'd2);
    check("b2_detect", 32'(detect), 32'd1);
    set_frames(16'd500, 16'd1000, 16'd999, 16'd999);
    tick(5);
    pulse_trig();
    tick(100);
    check("b3_hold_hits", 32'(hit_count), 32'd2);
    check("b3_hold_detect", 32'(detect), 32'd1);
    wait_bd(3, 2000);
    check("b3_hits", 32'(hit_count), 32'd1);
    check("b3_detect", 32'(detect), 32'd0);

    // Free-run: three chained bursts with one warm-up, release mid third burst.
    set_frames(16'h0FA0, 16'h0FA0, 16'h0FA0, 16'h0FA0);
    tick(5);
    base_bd = bd_cnt; base_sv = sv_cnt;
    en_rise_cnt = 0; en_fall_cnt = 0;
    force_fs = 1'b1;
    wait_bd(base_bd + 2, 2000);
    check("fs_no_en_drop", 32'(en_fall_cnt), 32'd0);
    check("fs_bd_spacing", 32'(bd_gap), 32'd297);
    tick(100);
    force_fs = 1'b0;
    wait_bd(base_bd + 3, 1000);
    check("fs_bd_spacing3", 32'(bd_gap), 32'd297);
    tick(3);
    check("fs_one_warmup", 32'(en_rise_cnt), 32'd1);
    check("fs_en_drop_end", 32'(en_fall_cnt), 32'd1);
    check("fs_sv_count", 32'(sv_cnt - base_sv), 32'd12);
    check("fs_en_off", 32'(lt5534_en), 32'd0);
    check("fs_idle", 32'(busy), 32'd0);
    check("fs_hits", 32'(hit_count), 32'd4);
    check("fs_detect", 32'(detect), 32'd1);

    // Reset during bit 9 of the second conversion, then a clean restart.
    base_cs = cs_fall_cnt; base_sv = sv_cnt;
    pulse_trig();
    n = 0;
    while (cs_fall_cnt < base_cs + 2 && n < 1000) begin
      tick(1);
      n++;
    end
    check("rst_mid_reached", 32'(cs_fall_cnt - base_cs), 32'd2);
    tick(32);
    reset = 1'b1;
    tick(1);
    check_reset_outputs("rst_mid");
    tick(1);
    reset = 1'b0;
    tick(100);
    check("rst_mid_no_strobe", 32'(sv_cnt - base_sv), 32'd1);
    base_bd = bd_cnt; base_sv = sv_cnt;
    pulse_trig();
    wait_bd(base_bd + 1, 2000);
    check("restart_warmup", 32'(warm_meas), 32'd50);
    check("restart_sv_count", 32'(sv_cnt - base_sv), 32'd4);
    check("restart_hits", 32'(hit_count), 32'd4);

    // CLK_DIV=1 instance: bit order and exact frame length.
    trig1 = 1'b1;
    tick(1);
    trig1 = 1'b0;
    tick(60);
    check("cd1_sv_count", 32'(sv1_cnt), 32'd1);
    check("cd1_sample_data", 32'(sdata1), 32'h0ABC);
    check("cd1_conv_len", 32'(conv_len1), 32'd32);
    check("cd1_cs_low_len", 32'(cs1_len), 32'd32);
    check("cd1_sclk_rises", 32'(nrise1_end), 32'd16);
    check("cd1_bd_count", 32'(bd1_cnt), 32'd1);
    check("cd1_hits", 32'(hit1), 32'd1);
    check("cd1_detect", 32'(detect1), 32'd1);
    check("cd1_idle", 32'(busy1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
